match_memory_paged: RTL and testbench

Parametrised, BX-paged successor to the match output buffer: stores valid match words from the match calculator into one RAM page per bunch crossing (BX), selected by in-band header words. It keeps a per-page entry count and serves whole-page readouts to the downstream track-fit stage through a ready/valid stream. Single clock domain; sits between match calculator and fitter.

---
 rtl/match_mem_pkg.sv | 15 +
 rtl/sdp_ram.sv | 23 ++
 rtl/match_memory_paged.sv | 152 +++++++++++++++
 tb/tb_match_memory_paged.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/match_mem_pkg.sv
// rtl/match_mem_pkg.sv - shared constants and read FSM states for the paged match memory
package match_mem_pkg;

  localparam logic [3:0] HDR_CODE_DEFAULT = 4'hF;
  localparam int         HDR_CODE_W       = 4;
  // The BX page field sits directly below the code field.
  localparam int         HDR_BX_OFS       = HDR_CODE_W;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_FETCH,
    RD_STREAM
  } rd_state_t;

endpackage

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port RAM, one clock, registered read-first output
module sdp_ram #(
  parameter int WIDTH = 44,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2**AW];

  // A same-address write and read returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/match_memory_paged.sv
// rtl/match_memory_paged.sv - BX-paged match buffer with per-page counts and stream readout
module match_memory_paged
  import match_mem_pkg::*;
#(
  parameter int         WIDTH    = 44,
  parameter int         DEPTH    = 64,
  parameter int         PBITS    = 3,
  parameter logic [3:0] HDR_CODE = HDR_CODE_DEFAULT
) (
  input  logic             proc_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] match,
  input  logic             valid,
  input  logic             rd_start,
  input  logic [PBITS-1:0] rd_bx,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] matchout,
  output logic             matchout_valid,
  output logic             matchout_last,
  output logic             rd_done,
  output logic             rd_busy,
  output logic             overflow,
  output logic [7:0]       drop_cnt,
  output logic [PBITS-1:0] wr_bx
);

  localparam int             ABITS = $clog2(DEPTH);
  localparam int             NPAGE = 2**PBITS;
  localparam int             AW    = PBITS + ABITS;
  localparam logic [ABITS:0] ONE   = 1;

  logic [ABITS:0]     wr_ptr;
  logic [ABITS:0]     count [NPAGE];
  logic               is_hdr, is_dat, ram_we;
  logic [PBITS-1:0]   new_bx;

  rd_state_t          state;
  logic [PBITS-1:0]   rd_page;
  logic [ABITS:0]     nrd, rd_idx, ld_idx;
  logic               pend, empty_pend;
  logic               load, ram_re, last_acc;
  logic [WIDTH-1:0]   ram_rdata;

  assign is_hdr = valid && (match[WIDTH-1 -: HDR_CODE_W] == HDR_CODE);
  assign is_dat = valid && !is_hdr;
  assign new_bx = match[WIDTH-1-HDR_BX_OFS -: PBITS];
  assign ram_we = is_dat && !wr_ptr[ABITS];

  always_ff @(posedge proc_clk or negedge reset) begin
    if (!reset) begin
      wr_bx    <= '0;
      wr_ptr   <= '0;
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
      for (int i = 0; i < NPAGE; i++) count[i] <= '0;
    end else if (is_hdr) begin
      wr_bx         <= new_bx;
      wr_ptr        <= '0;
      count[new_bx] <= '0;
    end else if (is_dat) begin
      if (!wr_ptr[ABITS]) begin
        wr_ptr       <= wr_ptr + ONE;
        count[wr_bx] <= count[wr_bx] + ONE;
      end else begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // RAM output acts as a one-word stage ahead of matchout; refill it only when
  // it is empty or its word moves into matchout this cycle.
  assign load     = !matchout_valid || rd_ready;
  assign ram_re   = (state == RD_FETCH) ||
                    ((state == RD_STREAM) && (rd_idx < nrd) && (!pend || load));
  assign last_acc = (state == RD_STREAM) && matchout_valid && matchout_last && rd_ready;

  sdp_ram #(.WIDTH(WIDTH), .AW(AW)) u_ram (
    .clk   (proc_clk),
    .we    (ram_we),
    .waddr ({wr_bx, wr_ptr[ABITS-1:0]}),
    .wdata (match),
    .re    (ram_re),
    .raddr ({rd_page, rd_idx[ABITS-1:0]}),
    .rdata (ram_rdata)
  );

  always_ff @(posedge proc_clk or negedge reset) begin
    if (!reset) begin
      state          <= RD_IDLE;
      rd_page        <= '0;
      nrd            <= '0;
      rd_idx         <= '0;
      ld_idx         <= '0;
      pend           <= 1'b0;
      empty_pend     <= 1'b0;
      matchout       <= '0;
      matchout_valid <= 1'b0;
      matchout_last  <= 1'b0;
      rd_done        <= 1'b0;
      rd_busy        <= 1'b0;
    end else begin
      rd_done    <= empty_pend;
      empty_pend <= 1'b0;
      case (state)
        RD_IDLE: begin
          if (rd_start) begin
            rd_page <= rd_bx;
            nrd     <= count[rd_bx];
            rd_idx  <= '0;
            ld_idx  <= '0;
            pend    <= 1'b0;
            if (count[rd_bx] == '0) begin
              empty_pend <= 1'b1;
            end else begin
              state   <= RD_FETCH;
              rd_busy <= 1'b1;
            end
          end
        end
        RD_FETCH: begin
          rd_idx <= rd_idx + ONE;
          pend   <= 1'b1;
          state  <= RD_STREAM;
        end
        RD_STREAM: begin
          if (last_acc) begin
            matchout_valid <= 1'b0;
            matchout_last  <= 1'b0;
            pend           <= 1'b0;
            rd_busy        <= 1'b0;
            rd_done        <= 1'b1;
            state          <= RD_IDLE;
          end else begin
            if (ram_re) rd_idx <= rd_idx + ONE;
            if (load) begin
              matchout_valid <= pend;
              matchout_last  <= pend && (ld_idx == nrd - ONE);
              if (pend) begin
                matchout <= ram_rdata;
                ld_idx   <= ld_idx + ONE;
              end
            end
            pend <= ram_re ? 1'b1 : (load ? 1'b0 : pend);
          end
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_memory_paged.sv
// tb/tb_match_memory_paged.sv - directed vector and sequence bench for match_memory_paged
module tb_match_memory_paged;

  localparam int W  = 44;
  localparam int D  = 64;
  localparam int PB = 3;

  logic          proc_clk = 1'b0;
  logic          reset    = 1'b0;
  logic [W-1:0]  match    = '0;
  logic          valid    = 1'b0;
  logic          rd_start = 1'b0;
  logic [PB-1:0] rd_bx    = '0;
  logic          rd_ready = 1'b1;
  logic [W-1:0]  matchout;
  logic          matchout_valid, matchout_last, rd_done, rd_busy, overflow;
  logic [7:0]    drop_cnt;
  logic [PB-1:0] wr_bx;

  int n_tests = 0;
  int n_fail  = 0;

  match_memory_paged #(.WIDTH(W), .DEPTH(D), .PBITS(PB), .HDR_CODE(4'hF)) dut (
    .proc_clk       (proc_clk),
    .reset          (reset),
    .match          (match),
    .valid          (valid),
    .rd_start       (rd_start),
    .rd_bx          (rd_bx),
    .rd_ready       (rd_ready),
    .matchout       (matchout),
    .matchout_valid (matchout_valid),
    .matchout_last  (matchout_last),
    .rd_done        (rd_done),
    .rd_busy        (rd_busy),
    .overflow       (overflow),
    .drop_cnt       (drop_cnt),
    .wr_bx          (wr_bx)
  );

  always #5 proc_clk = ~proc_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic          v;
    logic [W-1:0]  m;
    logic          st;
    logic [PB-1:0] bx;
    logic          rdy;
    logic          e_mv;
    logic [W-1:0]  e_d;
    logic          e_last;
    logic          e_done;
    logic          e_busy;
    logic [PB-1:0] e_wbx;
  } vec_t;

  vec_t tbl [15];

  logic [W-1:0] got_q [$];
  logic [W-1:0] exp_q [$];
  int           last_cnt, last_at, stall_bad;
  bit           done_seen;

  function automatic logic [W-1:0] hdr(input logic [PB-1:0] bx);
    return {4'hF, bx, 37'd0};
  endfunction

  function automatic logic [W-1:0] dw(input int tag, input int k);
    return {4'h1, 8'(tag), 32'(k)};
  endfunction

  function automatic vec_t mk(input logic v, input logic [W-1:0] m, input logic st,
                              input logic [PB-1:0] bx, input logic mv, input logic [W-1:0] d,
                              input logic last, input logic done, input logic busy,
                              input logic [PB-1:0] wbx);
    vec_t r;
    r.v = v; r.m = m; r.st = st; r.bx = bx; r.rdy = 1'b1;
    r.e_mv = mv; r.e_d = d; r.e_last = last; r.e_done = done; r.e_busy = busy; r.e_wbx = wbx;
    return r;
  endfunction

  task automatic tick;
    @(posedge proc_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [W-1:0] w);
    match = w;
    valid = 1'b1;
    tick;
    valid = 1'b0;
  endtask

  task automatic read_page(input logic [PB-1:0] bx, input bit toggle, input bit spam);
    logic         held_v, held_l;
    logic [W-1:0] held_d;
    got_q.delete();
    last_cnt = 0; last_at = -1; stall_bad = 0; done_seen = 0;
    rd_start = 1'b1; rd_bx = bx; rd_ready = 1'b1;
    tick;
    rd_start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rd_ready = toggle ? (c % 2 == 1) : 1'b1;
      rd_start = spam && rd_busy;
      rd_bx    = 3'd1;
      if (matchout_valid && rd_ready) begin
        got_q.push_back(matchout);
        if (matchout_last) begin
          last_cnt++;
          last_at = got_q.size() - 1;
        end
      end
      held_v = matchout_valid && !rd_ready;
      held_d = matchout;
      held_l = matchout_last;
      tick;
      if (held_v && (!matchout_valid || matchout !== held_d || matchout_last !== held_l))
        stall_bad++;
      if (rd_done) begin
        done_seen = 1;
        break;
      end
    end
    rd_start = 1'b0;
    rd_ready = 1'b1;
  endtask

  task automatic check_read(input string nm);
    int bad;
    bad = 0;
    chk({nm, " count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    chk({nm, " data"}, 64'(bad), 64'd0);
    chk({nm, " last"}, {32'(last_cnt), 32'(last_at)}, {32'd1, 32'(exp_q.size() - 1)});
    chk({nm, " stall"}, 64'(stall_bad), 64'd0);
    chk({nm, " done"}, 64'(done_seen), 64'd1);
  endtask

  task automatic empty_read(input string nm, input logic [PB-1:0] bx);
    rd_start = 1'b1; rd_bx = bx;
    tick;
    rd_start = 1'b0;
    chk({nm, " t"}, {61'd0, matchout_valid, rd_done, rd_busy}, 64'd0);
    tick;
    chk({nm, " t+1"}, {61'd0, matchout_valid, rd_done, rd_busy}, 64'b010);
    tick;
    chk({nm, " t+2"}, {61'd0, matchout_valid, rd_done, rd_busy}, 64'd0);
  endtask

  initial begin
    tbl[0] = mk(1, hdr(3), 0, 0, 0, '0, 0, 0, 0, 3);
    for (int i = 1; i <= 5; i++) tbl[i] = mk(1, dw(1, i - 1), 0, 0, 0, '0, 0, 0, 0, 3);
    tbl[6] = mk(0, '0, 1, 3, 0, '0, 0, 0, 1, 3);
    tbl[7] = mk(0, '0, 0, 0, 0, '0, 0, 0, 1, 3);
    for (int i = 8; i <= 12; i++) tbl[i] = mk(0, '0, 0, 0, 1, dw(1, i - 8), i == 12, 0, 1, 3);
    tbl[13] = mk(0, '0, 0, 0, 0, '0, 0, 1, 0, 3);
    tbl[14] = mk(0, '0, 0, 0, 0, '0, 0, 0, 0, 3);

    tick;
    tick;
    chk("reset state", {matchout, matchout_valid, matchout_last, rd_done, rd_busy, overflow, drop_cnt, wr_bx},
        64'd0);
    reset = 1'b1;
    tick;

    for (int i = 0; i < 15; i++) begin
      valid = tbl[i].v; match = tbl[i].m; rd_start = tbl[i].st; rd_bx = tbl[i].bx; rd_ready = tbl[i].rdy;
      tick;
      chk($sformatf("vec%0d", i),
          {13'd0, matchout_valid, matchout_valid ? matchout : 44'd0, matchout_last, rd_done, rd_busy, wr_bx},
          {13'd0, tbl[i].e_mv, tbl[i].e_d, tbl[i].e_last, tbl[i].e_done, tbl[i].e_busy, tbl[i].e_wbx});
    end
    valid = 1'b0; rd_start = 1'b0;

    wr(hdr(1)); wr(dw(2, 0)); wr(dw(2, 1));
    wr(hdr(2)); wr(dw(3, 0)); wr(dw(3, 1)); wr(dw(3, 2));
    read_page(1, 0, 0);
    exp_q = '{dw(2, 0), dw(2, 1)};
    check_read("page1");
    read_page(2, 0, 0);
    exp_q = '{dw(3, 0), dw(3, 1), dw(3, 2)};
    check_read("page2");

    wr(hdr(5));
    for (int k = 0; k < 4; k++) wr(dw(5, k));
    read_page(5, 1, 1);
    exp_q = '{dw(5, 0), dw(5, 1), dw(5, 2), dw(5, 3)};
    check_read("backpressure");
    tick;
    chk("start ignored while busy", {63'd0, rd_busy}, 64'd0);

    chk("no overflow yet", {55'd0, overflow, drop_cnt}, 64'd0);
    wr(hdr(6));
    for (int k = 0; k < D + 3; k++) wr(dw(6, k));
    chk("overflow flags", {55'd0, overflow, drop_cnt}, {55'd0, 1'b1, 8'd3});
    read_page(6, 0, 0);
    exp_q.delete();
    for (int k = 0; k < D; k++) exp_q.push_back(dw(6, k));
    check_read("full page");

    empty_read("never written", 7);
    wr(hdr(4)); wr(dw(4, 0)); wr(dw(4, 1));
    wr(hdr(4));
    chk("wr_bx after header", 64'(wr_bx), 64'd4);
    empty_read("rehead page4", 4);

    rd_start = 1'b1; rd_bx = 6; rd_ready = 1'b1;
    tick;
    rd_start = 1'b0;
    repeat (5) tick;
    chk("mid-readout valid", {62'd0, matchout_valid, rd_busy}, 64'b11);
    reset = 1'b0;
    #1;
    chk("async reset", {matchout, matchout_valid, matchout_last, rd_done, rd_busy, overflow, drop_cnt, wr_bx},
        64'd0);
    tick;
    tick;
    reset = 1'b1;
    tick;
    empty_read("page6 after reset", 6);
    empty_read("page3 after reset", 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
